// File: rtl/ram_stream_reader.sv
// Strided RAM reader: issues reads at base, base+stride, ... and streams
// the returned words through a 2-entry buffer with valid/ready flow control.
module ram_stream_reader #(
    parameter int BDADDR = 12,
    parameter int BDWORD = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BDADDR-1:0] base_addr,
    input  logic [BDADDR-1:0] stride,
    input  logic [BDADDR:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [BDADDR-1:0] rd_addr,
    input  logic [BDWORD-1:0] rd_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BDWORD-1:0] out_word,
    output logic              out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [BDADDR:0] REM_ONE = (BDADDR+1)'(1);

    state_t            state_q, state_d;
    logic [BDADDR-1:0] addr_q, addr_d;
    logic [BDADDR-1:0] stride_q, stride_d;
    logic [BDADDR:0]   rem_q, rem_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic              done_q, done_d;
    logic [1:0]        occ_q, occ_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        last_q;
    logic [BDWORD-1:0] mem_q [2];
    logic              pop;

    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_word  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & last_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rd_addr   = addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        occ_d       = occ_q + {1'b0, pend_q} - {1'b0, pop};
        wr_ptr_d    = wr_ptr_q ^ pend_q;
        rd_ptr_d    = rd_ptr_q ^ pop;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    stride_d = stride;
                    rem_d    = count;
                    state_d  = (count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                // buffer + in-flight read after this cycle's pop must leave room
                rd_en = ({1'b0, occ_q} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop});
                if (rd_en) begin
                    pend_d      = 1'b1;
                    pend_last_d = (rem_q == REM_ONE);
                    addr_d      = addr_q + stride_q;
                    rem_d       = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_d == 2'd0 && !pend_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            last_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            done_q      <= done_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            if (pend_q) last_q[wr_ptr_q] <= pend_last_q;
        end
    end

    // data storage needs no reset; occupancy gates its visibility
    always_ff @(posedge clk) begin
        if (rst_n && pend_q) mem_q[wr_ptr_q] <= rd_word;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter BDADDR, default 12, meaning RAM address width.
REQ-002 SHALL have parameter BDWORD, default 2048, meaning RAM word width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  BDADDR  first word address, captured on accepted start.
REQ-007 SHALL have port stride  input  BDADDR  address increment, captured on accepted start.
REQ-008 SHALL have port count  input  BDADDR+1  words to read (0..2^BDADDR), captured on accepted start.
REQ-009 SHALL have port busy  output  1  job in progress.
REQ-010 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-011 SHALL have port rd_en  output  1  RAM read strobe.
REQ-012 SHALL have port rd_addr  output  BDADDR  RAM read address.
REQ-013 SHALL have port rd_word  input  BDWORD  RAM data; valid exactly one cycle after the address is presented.
REQ-014 SHALL have port out_valid  output  1  stream data valid.
REQ-015 SHALL have port out_ready  input  1  stream sink ready.
REQ-016 SHALL have port out_word  output  BDWORD  stream data.
REQ-017 SHALL have port out_last  output  1  marks final word of the job.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 SHALL accept start only in IDLE; it captures base_addr/stride/count and moves to RUN on that edge; start outside IDLE SHALL be ignored.
REQ-020 SHALL, for accepted start with count=0, go to DRAIN with no reads; done pulses the following cycle and no words are emitted.
REQ-021 SHALL assert busy in RUN and DRAIN, deasserted in IDLE.
REQ-022 SHALL, in RUN, issue a read (rd_en=1) in a cycle iff fifo_occ + pending - pop < 2, where pending means the read issued the previous cycle, pop means out_valid&&out_ready this cycle, and fifo_occ is the 2-entry output buffer occupancy.
REQ-023 SHALL issue the first read at rd_addr=base_addr; each subsequent issued read SHALL use the previous address + stride, modulo 2^BDADDR (wrap-around silent).
REQ-024 SHALL hold rd_addr unchanged in cycles with rd_en=0.
REQ-025 SHALL write rd_word into the output buffer on the cycle after every issued read, never on any other cycle; rd_word outside those cycles is ignored.
REQ-026 SHALL move RUN->DRAIN on the edge where the count-th read is issued.
REQ-027 SHALL move DRAIN->IDLE when the buffer is empty, no read is pending, and the last word has been popped; done SHALL pulse for exactly one cycle after the edge where the word with out_last was accepted.
REQ-028 SHALL present buffer words in issue order; out_word/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 SHALL assert out_last only with the count-th word.
REQ-030 SHALL place out_valid 2 cycles after the start-accept edge (read issue, RAM latency, buffer write) and sustain one word per cycle while out_ready=1.
REQ-031 SHALL never overflow the buffer or drop a RAM word, for any out_ready pattern.
REQ-032 SHALL keep rd_en=0 in IDLE and DRAIN.

Reset
REQ-033 SHALL, while rst_n=0 at a clock edge, force state=IDLE, busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_last=0, out_word=0, buffer empty, pending cleared.
REQ-034 SHALL abandon any in-flight job on reset mid-operation: no done pulse, no further words; the returning rd_word is discarded.
REQ-035 SHALL accept start in the first cycle with rst_n=1.

Verification
REQ-036 Bench SHALL check base=0x010, stride=1, count=4, out_ready=1 -> rd_addr 0x010..0x013 on consecutive cycles; words out consecutively with the first 2 cycles after start; out_last on word 4; done one cycle later.
REQ-037 Bench SHALL check base=0xFFE, stride=3, count=3 (BDADDR=12) -> rd_addr 0xFFE, 0x001, 0x004.
REQ-038 Bench SHALL check count=8 with out_ready toggling 1,0,0,1 repeating -> all 8 words in order, no duplicates/losses, rd_en never issued when buffer+pending would exceed 2.
REQ-039 Bench SHALL check count=0 -> busy 1 for one cycle, done pulse, out_valid never asserted, rd_en never asserted.
REQ-040 Bench SHALL check start re-asserted during a count=5 job -> ignored; exactly 5 words, one done.
REQ-041 Bench SHALL check rst_n=0 after 2 of 6 words -> all outputs 0 next cycle, no done; new job after reset completes correctly.
